irq_controller: RTL and testbench

//  Memory-mapped interrupt controller between device IRQ sources (timer0, timer1, outer

---
 rtl/irq_controller_if.sv | 21 ++
 rtl/irq_controller.sv | 118 +++++++++++
 tb/tb_irq_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Bus and IRQ signals between the Bridge/CPU side and the interrupt controller.
// master = Bridge/CPU side (drives address, strobe, write data, device sources);
// slave  = controller (drives read data and the irq vector).
interface irq_controller_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [5:0]  irq_src;
  logic [5:0]  irq;

  modport master (
    output Addr, WE, Din, irq_src,
    input  Dout, irq
  );

  modport slave (
    input  Addr, WE, Din, irq_src,
    output Dout, irq
  );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-line capture, edge/level mode, pending, mask, W1C ack.
// Latency: source to irq 1 cycle (3 cycles when IRQ_SYNC_EN adds a 2-flop synchronizer); Dout is combinational.
// Backpressure: none; writes always accepted in one cycle, reads never stall.
module irq_controller #(
  parameter int           N_LINES    = 6,
  parameter logic [5:0]   MODE_RESET = 6'b0
) (
  input  logic           clk,
  input  logic           reset,
  irq_controller_if.slave bus
);

  // Bits at or above N_LINES are tied off everywhere.
  localparam logic [5:0] LINE_MASK = 6'((1 << N_LINES) - 1);

  localparam logic [2:0] A_MASK    = 3'd0;
  localparam logic [2:0] A_MODE    = 3'd1;
  localparam logic [2:0] A_PENDING = 3'd2;
  localparam logic [2:0] A_RAW     = 3'd3;
  localparam logic [2:0] A_ID      = 3'd4;

  logic [5:0]  mask_q;
  logic [5:0]  mode_q;
  logic [5:0]  pending_q;
  logic [5:0]  prev_q;
  logic [5:0]  s;
  logic [5:0]  pending_nxt;
  logic [5:0]  active;
  logic [31:0] id_val;
  logic [2:0]  reg_sel;
  logic        wr_mask;
  logic        wr_mode;
  logic        wr_pending;

  // The Bridge does base decode; only the word offset and the low data bits matter here.
  logic unused_bits;
  assign unused_bits = ^{bus.Addr[31:5], bus.Addr[1:0], bus.Din[31:6]};

  assign reg_sel    = bus.Addr[4:2];
  assign wr_mask    = bus.WE && (reg_sel == A_MASK);
  assign wr_mode    = bus.WE && (reg_sel == A_MODE);
  assign wr_pending = bus.WE && (reg_sel == A_PENDING);

`ifdef IRQ_SYNC_EN
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;

  // Two-flop synchronizer for sources that may come from another clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q & LINE_MASK;
`else
  // Sources already live on clk, so they are sampled directly.
  assign s = bus.irq_src & LINE_MASK;
`endif

  // Next pending: edge lines latch rising edges and honour W1C (a new edge beats a
  // same-cycle clear); level lines simply follow the sampled source.
  always_comb begin
    logic [5:0] w1c;
    logic [5:0] edge_set;
    logic [5:0] edge_next;
    w1c         = wr_pending ? bus.Din[5:0] : 6'b0;
    edge_set    = s & ~prev_q;
    edge_next   = (pending_q & ~w1c) | edge_set;
    pending_nxt = ((mode_q & edge_next) | (~mode_q & s)) & LINE_MASK;
  end

  // Register file, edge-detect history and pending latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      mode_q    <= MODE_RESET & LINE_MASK;
      pending_q <= '0;
      prev_q    <= '0;
    end else begin
      prev_q    <= s;
      pending_q <= pending_nxt;
      if (wr_mask) mask_q <= bus.Din[5:0] & LINE_MASK;
      if (wr_mode) mode_q <= bus.Din[5:0] & LINE_MASK;
    end
  end

  assign active = pending_q & mask_q;

  // Lowest active line wins; all-ones means nothing is requesting.
  always_comb begin
    id_val = 32'hFFFF_FFFF;
    for (int i = 5; i >= 0; i--) begin
      if (active[i]) id_val = 32'(i);
    end
  end

  // Combinational read mux; unmapped offsets read zero.
  always_comb begin
    bus.Dout = 32'h0;
    case (reg_sel)
      A_MASK:    bus.Dout = {26'b0, mask_q};
      A_MODE:    bus.Dout = {26'b0, mode_q};
      A_PENDING: bus.Dout = {26'b0, pending_q};
      A_RAW:     bus.Dout = {26'b0, s};
      A_ID:      bus.Dout = id_val;
      default:   bus.Dout = 32'h0;
    endcase
  end

  // Requests are forced low while reset is held, even before the first reset edge.
  assign bus.irq = reset ? 6'b0 : active;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller; expected values queued as stimulus is applied.
// Works with and without IRQ_SYNC_EN (source-to-pending latency LAT).
// No flow control on the DUT; all waits are fixed cycle counts.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam logic [31:0] R_MASK    = 32'h00;
  localparam logic [31:0] R_MODE    = 32'h04;
  localparam logic [31:0] R_PENDING = 32'h08;
  localparam logic [31:0] R_RAW     = 32'h0C;
  localparam logic [31:0] R_ID      = 32'h10;
  localparam logic [31:0] R_RSVD    = 32'h14;

  logic clk;
  logic reset;

  irq_controller_if bus ();

  irq_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.Addr = addr;
    bus.Din  = data;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    push_exp(tag, exp);
    bus.Addr = addr;
    #1;
    pop_cmp(bus.Dout);
  endtask

  task automatic irq_chk(input string tag, input logic [5:0] exp);
    push_exp(tag, {26'b0, exp});
    #1;
    pop_cmp({26'b0, bus.irq});
  endtask

  initial begin
    bus.Addr    = 32'h0;
    bus.WE      = 1'b0;
    bus.Din     = 32'h0;
    bus.irq_src = 6'h3F;
    reset       = 1'b1;

    // Reset held 2 cycles with all sources high
    tick();
    tick();
    irq_chk("rst_irq", 6'h00);
    rd_chk("rst_mask", R_MASK, 32'h0);
    rd_chk("rst_pending", R_PENDING, 32'h0);
    rd_chk("rst_mode", R_MODE, 32'h0);
    reset = 1'b0;
    repeat (LAT) tick();
    rd_chk("post_rst_pending", R_PENDING, 32'h3F);
    irq_chk("post_rst_irq", 6'h00);

    // Edge capture on line 0 and W1C acknowledge
    bus.irq_src = 6'h00;
    repeat (LAT + 1) tick();
    wr(R_MODE, 32'h01);
    wr(R_MASK, 32'h01);
    bus.irq_src = 6'h01;
    tick();
    bus.irq_src = 6'h00;
    repeat (LAT - 1) tick();
    irq_chk("edge_irq", 6'h01);
    repeat (2) tick();
    irq_chk("edge_irq_hold", 6'h01);
    rd_chk("edge_id", R_ID, 32'h0);
    wr(R_PENDING, 32'h01);
    irq_chk("edge_w1c_irq", 6'h00);
    rd_chk("edge_w1c_id", R_ID, 32'hFFFF_FFFF);

    // Level line 2: follows source for 3 cycles, W1C mid-pulse ignored
    wr(R_MODE, 32'h00);
    wr(R_MASK, 32'h04);
    bus.irq_src = 6'h04;
    for (int j = 1; j <= LAT + 4; j++) begin
      push_exp($sformatf("level_irq_c%0d", j), (j >= LAT && j <= LAT + 2) ? 32'h04 : 32'h00);
      if (j == 2) wr(R_PENDING, 32'h04);
      else tick();
      if (j == 3) bus.irq_src = 6'h00;
      pop_cmp({26'b0, bus.irq});
    end

    // Rising edge and W1C on the same cycle: the edge wins
    wr(R_MODE, 32'h02);
    wr(R_MASK, 32'h02);
    bus.irq_src = 6'h02;
    repeat (LAT - 1) tick();
    wr(R_PENDING, 32'h02);
    rd_chk("collide_pending", R_PENDING, 32'h02);
    irq_chk("collide_irq", 6'h02);

    // Masked edges stay latched; priority selects the lowest unmasked line
    bus.irq_src = 6'h00;
    repeat (LAT + 1) tick();
    wr(R_MODE, 32'h3F);
    wr(R_MASK, 32'h00);
    wr(R_PENDING, 32'h3F);
    rd_chk("clr_pending", R_PENDING, 32'h00);
    bus.irq_src = 6'h28;
    tick();
    bus.irq_src = 6'h00;
    repeat (LAT + 1) tick();
    rd_chk("masked_pending", R_PENDING, 32'h28);
    irq_chk("masked_irq", 6'h00);
    wr(R_MASK, 32'h20);
    irq_chk("unmask5_irq", 6'h20);
    rd_chk("unmask5_id", R_ID, 32'd5);
    wr(R_MASK, 32'h28);
    rd_chk("unmask35_id", R_ID, 32'd3);
    irq_chk("unmask35_irq", 6'h28);

    // Held-high edge source sets once and re-arms only after a low cycle
    bus.irq_src = 6'h01;
    repeat (LAT + 1) tick();
    rd_chk("held_pending", R_PENDING, 32'h29);
    rd_chk("held_raw", R_RAW, 32'h01);
    wr(R_PENDING, 32'h01);
    repeat (3) tick();
    rd_chk("held_no_reset", R_PENDING, 32'h28);
    bus.irq_src = 6'h00;
    repeat (LAT + 1) tick();
    bus.irq_src = 6'h01;
    repeat (LAT + 1) tick();
    rd_chk("rearm_pending", R_PENDING, 32'h29);

    // Read-only and reserved offsets ignore writes
    wr(R_RAW, 32'h3F);
    rd_chk("raw_ro", R_RAW, 32'h01);
    wr(R_RSVD, 32'hFFFF_FFFF);
    rd_chk("rsvd_zero", R_RSVD, 32'h0);
    rd_chk("rsvd_mask_kept", R_MASK, 32'h28);

    // Reset in the middle of operation
    wr(R_PENDING, 32'h01);
    wr(R_MASK, 32'h3F);
    irq_chk("pre_rst_irq", 6'h28);
    reset       = 1'b1;
    bus.irq_src = 6'h3F;
    tick();
    reset = 1'b0;
    irq_chk("mid_rst_irq", 6'h00);
    rd_chk("mid_rst_mask", R_MASK, 32'h0);
    rd_chk("mid_rst_mode", R_MODE, 32'h0);
    rd_chk("mid_rst_pending", R_PENDING, 32'h0);
    rd_chk("mid_rst_id", R_ID, 32'hFFFF_FFFF);
    repeat (LAT - 1) tick();
    rd_chk("mid_rst_lat_pending", R_PENDING, 32'h0);
    tick();
    rd_chk("mid_rst_src_pending", R_PENDING, 32'h3F);
    irq_chk("mid_rst_src_irq", 6'h00);

    if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
